element_loader: RTL and testbench
=================================

ELEMENT_LOADER -- requirements
Module: element_loader

Interface
REQ-001 The module SHALL have parameter VALUE_W, default 10, width of the element value field.
REQ-002 The module SHALL have parameter EXP_W, default 10, width of the signed exponent field (MSB = sign).
REQ-003 The module SHALL have parameter NODE_W, default 5, width of each node index.
REQ-004 The module SHALL have parameter MAX_ELEM, default 32, element RAM depth; ADDR_W = clog2(MAX_ELEM), derived.
REQ-005 The module SHALL have parameter DIN_W, default 10; legal only if DIN_W >= max(VALUE_W, EXP_W, 2*NODE_W).
REQ-006 The module SHALL have these ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- data_in  in  DIN_W  switch value sampled on ld.
- ld  in  1  one-cycle load strobe.
- back  in  1  one-cycle strobe, return to previous field.
- clear  in  1  one-cycle strobe, discard element in progress.
- mem_addr  out  ADDR_W  element RAM address.
- mem_data  out  W  packed word {node_A, node_B, type[1:0], exponent, value}; W = 2*NODE_W+2+EXP_W+VALUE_W.
- mem_wren  out  1  RAM write enable.
- field  out  3  current state code, for the display block.
- element_count  out  ADDR_W+1  elements committed.
- full  out  1  element_count == MAX_ELEM.
- err  out  1  one-cycle pulse on a rejected ld.

Function
REQ-007 FSM states SHALL be: TYPE=0, VALUE=1, EXP=2, NODES=3, WRITE=4, FULL=5; field SHALL equal the state code.
REQ-008 ld in TYPE SHALL capture data_in[1:0] as type and move to VALUE; type 3 SHALL be rejected (err=1 next cycle, state held).
REQ-009 ld in VALUE SHALL capture data_in[VALUE_W-1:0] and move to EXP.
REQ-010 ld in EXP SHALL capture data_in[EXP_W-1:0] and move to NODES.
REQ-011 ld in NODES SHALL capture node_A=data_in[2*NODE_W-1:NODE_W], node_B=data_in[NODE_W-1:0] and move to WRITE.
REQ-012 WRITE SHALL last exactly one cycle: mem_wren=1, mem_addr=element_count[ADDR_W-1:0], mem_data=packed word.
REQ-013 On leaving WRITE, element_count SHALL increment by 1 and the state SHALL become FULL if the new count equals MAX_ELEM, else TYPE.
REQ-014 mem_wren SHALL be 0 in every state except WRITE; no second write per element.
REQ-015 back SHALL move VALUE->TYPE, EXP->VALUE, NODES->EXP; in TYPE, WRITE and FULL it SHALL be ignored; captured fields are retained.
REQ-016 clear SHALL zero type, value, exponent and nodes and go to TYPE from any state except WRITE and FULL; element_count is unchanged.
REQ-017 Priority per cycle SHALL be reset > clear > back > ld; ld, back and clear in WRITE SHALL be ignored.
REQ-018 In FULL, ld SHALL produce an err pulse and no write; only reset leaves FULL.
REQ-019 err SHALL be high for exactly one cycle per rejected ld, asserted the cycle after that ld.

Reset
REQ-020 Reset SHALL force state TYPE, element_count 0, all captured fields 0, mem_addr 0, mem_data 0, mem_wren 0, err 0, full 0.
REQ-021 Reset asserted during WRITE SHALL suppress that write: mem_wren=0 on the following cycle and count stays 0.

Configuration
REQ-022 With NODE_CHECK_EN defined, ld in NODES with node_A == node_B or either node >= MAX_ELEM SHALL be rejected (err pulse, state held); without it, any node pair SHALL be accepted.

Structure
REQ-023 State codes, default widths and the packed-word field offsets SHALL live in shared package element_pkg, for reuse by the solver stages.
REQ-024 One sub-module, element_pack, SHALL perform the combinational packing of fields into mem_data; the FSM and registers stay in element_loader.

Verification
REQ-025 Defaults: ld 2, 470, 3, {A=1,B=0} -> one WRITE cycle, mem_addr 0, mem_data 0x0820_0DD6 (node_A=1, node_B=0, type=2, exp=3, value=470), count 1, field 0.
REQ-026 ld type 3 in TYPE -> err pulse one cycle, field stays 0, no write.
REQ-027 In EXP, pulse back then ld 5 -> field 1, value overwritten to 5, exponent unchanged.
REQ-028 32 complete entries -> addresses 0..31 written once each, full=1, field 5; further ld -> err, no mem_wren.
REQ-029 Simultaneous clear and ld in NODES -> state TYPE, no write; reset in WRITE -> no mem_wren, count 0.
REQ-030 NODE_CHECK_EN defined, nodes A=4, B=4 -> err pulse, state NODES; undefined -> write with A=4, B=4.

Source files
------------

// File: rtl/element_pkg.sv
// rtl/element_pkg.sv - shared state codes, default widths and packed-word layout for the element loader
package element_pkg;

    typedef enum logic [2:0] {
        ST_TYPE  = 3'd0,
        ST_VALUE = 3'd1,
        ST_EXP   = 3'd2,
        ST_NODES = 3'd3,
        ST_WRITE = 3'd4,
        ST_FULL  = 3'd5
    } state_t;

    localparam int DEF_VALUE_W  = 10;
    localparam int DEF_EXP_W    = 10;
    localparam int DEF_NODE_W   = 5;
    localparam int DEF_MAX_ELEM = 32;
    localparam int DEF_DIN_W    = 10;

    localparam int TYPE_W = 2;
    localparam logic [TYPE_W-1:0] TYPE_RESERVED = 2'd3;

    // Word layout, LSB first: value, exponent, type, node_B, node_A.
    function automatic int exp_lsb(input int value_w);
        return value_w;
    endfunction

    function automatic int type_lsb(input int value_w, input int exp_w);
        return value_w + exp_w;
    endfunction

    function automatic int node_b_lsb(input int value_w, input int exp_w);
        return value_w + exp_w + TYPE_W;
    endfunction

    function automatic int node_a_lsb(input int value_w, input int exp_w, input int node_w);
        return value_w + exp_w + TYPE_W + node_w;
    endfunction

    function automatic int word_w(input int value_w, input int exp_w, input int node_w);
        return value_w + exp_w + TYPE_W + 2 * node_w;
    endfunction

endpackage

// File: rtl/element_pack.sv
// rtl/element_pack.sv - combinational packing of captured element fields into one RAM word
module element_pack
    import element_pkg::*;
#(
    parameter int VALUE_W = DEF_VALUE_W,
    parameter int EXP_W   = DEF_EXP_W,
    parameter int NODE_W  = DEF_NODE_W,
    localparam int W      = word_w(VALUE_W, EXP_W, NODE_W)
) (
    input  logic [NODE_W-1:0]  node_a,
    input  logic [NODE_W-1:0]  node_b,
    input  logic [TYPE_W-1:0]  elem_type,
    input  logic [EXP_W-1:0]   exponent,
    input  logic [VALUE_W-1:0] value,
    output logic [W-1:0]       word
);

    localparam int EXP_LSB    = exp_lsb(VALUE_W);
    localparam int TYPE_LSB   = type_lsb(VALUE_W, EXP_W);
    localparam int NODE_B_LSB = node_b_lsb(VALUE_W, EXP_W);
    localparam int NODE_A_LSB = node_a_lsb(VALUE_W, EXP_W, NODE_W);

    always_comb begin
        word = '0;
        word[0 +: VALUE_W]          = value;
        word[EXP_LSB +: EXP_W]      = exponent;
        word[TYPE_LSB +: TYPE_W]    = elem_type;
        word[NODE_B_LSB +: NODE_W]  = node_b;
        word[NODE_A_LSB +: NODE_W]  = node_a;
    end

endmodule

// File: rtl/element_loader.sv
// rtl/element_loader.sv - switch-driven element entry FSM that writes packed elements to RAM
// Optional NODE_CHECK_EN rejects degenerate or out-of-range node pairs.
module element_loader
    import element_pkg::*;
#(
    parameter int VALUE_W  = DEF_VALUE_W,
    parameter int EXP_W    = DEF_EXP_W,
    parameter int NODE_W   = DEF_NODE_W,
    parameter int MAX_ELEM = DEF_MAX_ELEM,
    parameter int DIN_W    = DEF_DIN_W,
    localparam int ADDR_W  = $clog2(MAX_ELEM),
    localparam int W       = word_w(VALUE_W, EXP_W, NODE_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DIN_W-1:0]  data_in,
    input  logic              ld,
    input  logic              back,
    input  logic              clear,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [W-1:0]      mem_data,
    output logic              mem_wren,
    output logic [2:0]        field,
    output logic [ADDR_W:0]   element_count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_ELEM);

    state_t state, state_next;

    logic [TYPE_W-1:0]  elem_type;
    logic [VALUE_W-1:0] value;
    logic [EXP_W-1:0]   exponent;
    logic [NODE_W-1:0]  node_a, node_b;

    logic cap_type, cap_value, cap_exp, cap_nodes, do_clear, err_next;
    logic node_bad, last_elem;

    logic [NODE_W-1:0] din_node_a, din_node_b;
    assign din_node_a = data_in[2*NODE_W-1:NODE_W];
    assign din_node_b = data_in[NODE_W-1:0];

`ifdef NODE_CHECK_EN
    assign node_bad = (din_node_a == din_node_b)
                   || ({{(32-NODE_W){1'b0}}, din_node_a} >= MAX_ELEM[31:0])
                   || ({{(32-NODE_W){1'b0}}, din_node_b} >= MAX_ELEM[31:0]);
`else
    assign node_bad = 1'b0;
`endif

    assign last_elem = (element_count + 1'b1) == MAX_CNT;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_TYPE;
        end else begin
            state <= state_next;
        end
    end

    // A strobe that has no effect in the current state is treated as absent,
    // so it does not mask a lower-priority strobe.
    always_comb begin
        state_next = state;
        cap_type   = 1'b0;
        cap_value  = 1'b0;
        cap_exp    = 1'b0;
        cap_nodes  = 1'b0;
        do_clear   = 1'b0;
        err_next   = 1'b0;
        case (state)
            ST_WRITE: state_next = last_elem ? ST_FULL : ST_TYPE;
            ST_FULL:  err_next = ld;
            default: begin
                if (clear) begin
                    do_clear   = 1'b1;
                    state_next = ST_TYPE;
                end else if (back && state != ST_TYPE) begin
                    case (state)
                        ST_VALUE: state_next = ST_TYPE;
                        ST_EXP:   state_next = ST_VALUE;
                        ST_NODES: state_next = ST_EXP;
                        default:  state_next = state;
                    endcase
                end else if (ld) begin
                    case (state)
                        ST_TYPE: begin
                            if (data_in[TYPE_W-1:0] == TYPE_RESERVED) begin
                                err_next = 1'b1;
                            end else begin
                                cap_type   = 1'b1;
                                state_next = ST_VALUE;
                            end
                        end
                        ST_VALUE: begin
                            cap_value  = 1'b1;
                            state_next = ST_EXP;
                        end
                        ST_EXP: begin
                            cap_exp    = 1'b1;
                            state_next = ST_NODES;
                        end
                        ST_NODES: begin
                            if (node_bad) begin
                                err_next = 1'b1;
                            end else begin
                                cap_nodes  = 1'b1;
                                state_next = ST_WRITE;
                            end
                        end
                        default: state_next = state;
                    endcase
                end
            end
        endcase
    end

    // Reset gates the write strobe immediately so a reset during WRITE never reaches the RAM.
    always_comb begin
        mem_wren = (state == ST_WRITE) && !reset;
        mem_addr = element_count[ADDR_W-1:0];
        field    = state;
        full     = (element_count == MAX_CNT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            elem_type     <= '0;
            value         <= '0;
            exponent      <= '0;
            node_a        <= '0;
            node_b        <= '0;
            element_count <= '0;
            err           <= 1'b0;
        end else begin
            err <= err_next;
            if (do_clear) begin
                elem_type <= '0;
                value     <= '0;
                exponent  <= '0;
                node_a    <= '0;
                node_b    <= '0;
            end
            if (cap_type)  elem_type <= data_in[TYPE_W-1:0];
            if (cap_value) value     <= data_in[VALUE_W-1:0];
            if (cap_exp)   exponent  <= data_in[EXP_W-1:0];
            if (cap_nodes) begin
                node_a <= din_node_a;
                node_b <= din_node_b;
            end
            if (state == ST_WRITE) element_count <= element_count + 1'b1;
        end
    end

    element_pack #(
        .VALUE_W (VALUE_W),
        .EXP_W   (EXP_W),
        .NODE_W  (NODE_W)
    ) u_pack (
        .node_a    (node_a),
        .node_b    (node_b),
        .elem_type (elem_type),
        .exponent  (exponent),
        .value     (value),
        .word      (mem_data)
    );

endmodule

// File: tb/tb_element_loader.sv
// tb/tb_element_loader.sv - directed self-checking bench for element_loader (default parameters)
module tb_element_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  data_in = '0;
    logic        ld = 1'b0;
    logic        back = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [2:0]  field;
    logic [5:0]  element_count;
    logic        full;
    logic        err;

    int checks = 0;
    int failures = 0;
    int total_writes = 0;
    int wr_cnt [32];
    int saved_writes;
    int bad_addrs;

    element_loader dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .ld            (ld),
        .back          (back),
        .clear         (clear),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_wren      (mem_wren),
        .field         (field),
        .element_count (element_count),
        .full          (full),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wren === 1'b1) begin
            total_writes++;
            wr_cnt[mem_addr]++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_ld(input logic [9:0] v);
        data_in = v;
        ld = 1'b1;
        step();
        ld = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        total_writes = 0;
        for (int i = 0; i < 32; i++) wr_cnt[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) wr_cnt[i] = 0;
        do_reset();

        check("rst_field", field, 0);
        check("rst_count", element_count, 0);
        check("rst_wren", mem_wren, 0);
        check("rst_data", mem_data, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_err", err, 0);
        check("rst_full", full, 0);

        // First element: type 2, value 470, exp 3, A=1 B=0
        do_ld(10'd2);
        check("ld_type_field", field, 1);
        do_ld(10'd470);
        do_ld(10'd3);
        check("ld_exp_field", field, 3);
        do_ld(10'd32);
        check("w0_field", field, 4);
        check("w0_wren", mem_wren, 1);
        check("w0_addr", mem_addr, 0);
        check("w0_data", mem_data, 32'h0820_0DD6);
        step();
        check("w0_after_field", field, 0);
        check("w0_after_count", element_count, 1);
        check("w0_after_wren", mem_wren, 0);
        check("w0_writes", total_writes, 1);

        // Reserved type is rejected
        do_ld(10'd3);
        check("t3_err", err, 1);
        check("t3_field", field, 0);
        step();
        check("t3_err_drop", err, 0);
        check("t3_field2", field, 0);
        check("t3_writes", total_writes, 1);

        // back from EXP then reload value
        do_ld(10'd1);
        do_ld(10'd7);
        check("bk_pre_field", field, 2);
        back = 1'b1;
        step();
        back = 1'b0;
        check("bk_field", field, 1);
        do_ld(10'd5);
        check("bk_reld_field", field, 2);
        do_ld(10'd6);
        do_ld({5'd2, 5'd1});
        check("w1_wren", mem_wren, 1);
        check("w1_addr", mem_addr, 1);
        check("w1_data", mem_data, 32'h1050_1805);
        step();
        check("w1_count", element_count, 2);

        // clear beats ld in NODES
        do_ld(10'd0);
        do_ld(10'd1);
        do_ld(10'd1);
        check("cl_pre_field", field, 3);
        data_in = 10'd33;
        clear = 1'b1;
        ld = 1'b1;
        step();
        clear = 1'b0;
        ld = 1'b0;
        check("cl_field", field, 0);
        check("cl_wren", mem_wren, 0);
        step();
        check("cl_count", element_count, 2);
        check("cl_writes", total_writes, 2);

        // reset while in WRITE suppresses the write
        do_ld(10'd0);
        do_ld(10'd1);
        do_ld(10'd1);
        saved_writes = total_writes;
        data_in = 10'd32;
        ld = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        ld = 1'b0;
        @(negedge clk);
        #1;
        check("rw_wren", mem_wren, 0);
        step();
        check("rw_field", field, 0);
        check("rw_count", element_count, 0);
        check("rw_wren2", mem_wren, 0);
        check("rw_writes", total_writes, saved_writes);
        reset = 1'b0;
        step();

        // Equal node pair
        do_ld(10'd0);
        do_ld(10'd0);
        do_ld(10'd0);
        do_ld({5'd4, 5'd4});
`ifdef NODE_CHECK_EN
        check("nc_err", err, 1);
        check("nc_field", field, 3);
        check("nc_wren", mem_wren, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
`else
        check("nc_field", field, 4);
        check("nc_wren", mem_wren, 1);
        check("nc_data", mem_data, 32'h2100_0000);
        step();
`endif

        // Fill all 32 entries
        do_reset();
        for (int i = 0; i < 32; i++) begin
            do_ld(10'(i % 3));
            do_ld(10'(i));
            do_ld(10'(i));
            do_ld({5'(i), 5'(31 - i)});
            check("fill_addr", mem_addr, 64'(i));
            step();
        end
        bad_addrs = 0;
        for (int i = 0; i < 32; i++) if (wr_cnt[i] != 1) bad_addrs++;
        check("fill_bad_addrs", bad_addrs, 0);
        check("fill_writes", total_writes, 32);
        check("fill_full", full, 1);
        check("fill_field", field, 5);
        check("fill_count", element_count, 32);

        do_ld(10'd1);
        check("full_err", err, 1);
        check("full_field", field, 5);
        check("full_wren", mem_wren, 0);
        clear = 1'b1;
        back = 1'b1;
        step();
        clear = 1'b0;
        back = 1'b0;
        check("full_err_drop", err, 0);
        check("full_stay", field, 5);
        check("full_writes", total_writes, 32);

        do_reset();
        check("post_full_field", field, 0);
        check("post_full_full", full, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
